// File: rtl/fir_alu_seq.sv
// fir_alu_seq: tap sequencer driving a shared pipelined 16x16 ALU for an FIR.
// Optional macro FIR_SAT_EN: saturate out_data to the signed 32-bit range.
module fir_alu_seq #(
    parameter int TAPS    = 8,
    parameter int ALU_LAT = 2,
    parameter int ACC_W   = 40,
    localparam int AW     = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [15:0]   coef_wdata,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    output logic [1:0]    alu_op_sel,
    input  logic [31:0]   alu_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

    state_t             state_q, state_d;
    logic [15:0]        x_q [TAPS];
    logic [15:0]        x_d [TAPS];
    logic [15:0]        coef_q [TAPS];
    logic [15:0]        coef_d [TAPS];
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [ALU_LAT-1:0] tag_q, tag_d;
    logic [15:0]        alu_a_q, alu_a_d;
    logic [15:0]        alu_b_q, alu_b_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic [31:0]        acc_fmt;
    logic               issue_d;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        coef_d  = coef_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        // A tag leaves the pipe exactly when its product arrives.
        tag_d   = ALU_LAT'({tag_q, state_q == ISSUE});
        if (tag_q[ALU_LAT-1]) begin
            acc_d = acc_q + {{(ACC_W-32){alu_result[31]}}, alu_result};
        end
        if (state_q == IDLE && coef_we && int'(coef_addr) < TAPS) begin
            coef_d[coef_addr] = coef_wdata;
        end
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d[0] = in_data;
                    for (int k = 1; k < TAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == AW'(TAPS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (tag_d == '0) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef FIR_SAT_EN
        if ((&acc_d[ACC_W-1:31]) || (~|acc_d[ACC_W-1:31])) begin
            acc_fmt = acc_d[31:0];
        end else if (acc_d[ACC_W-1]) begin
            acc_fmt = 32'h8000_0000;
        end else begin
            acc_fmt = 32'h7FFF_FFFF;
        end
`else
        acc_fmt = acc_d[31:0];
`endif
    end

    // Outputs are registered from the next-state values.
    always_comb begin
        issue_d     = (state_d == ISSUE);
        alu_a_d     = issue_d ? x_d[cnt_d] : '0;
        alu_b_d     = issue_d ? coef_d[cnt_d] : '0;
        alu_op_d    = issue_d ? 2'b01 : 2'b00;
        out_valid_d = (state_d == OUTPUT);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_data_d  = out_data_q;
        if (state_q == DRAIN && state_d == OUTPUT) begin
            out_data_d = acc_fmt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_q         <= '{default: '0};
            coef_q      <= '{default: '0};
            acc_q       <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            coef_q      <= coef_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op_sel = alu_op_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fir_alu_seq.sv
// Bench for fir_alu_seq: pipelined ALU model, FIR reference model, scoreboard.
`timescale 1ns/1ps
module tb_fir_alu_seq;

    localparam int TAPS = 8;
    localparam int LAT  = 2;
    localparam int P    = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_op_sel;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;

    always #(P/2) clk = ~clk;

    fir_alu_seq dut (
        .clk(clk), .rst(rst),
        .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_op_sel(alu_op_sel), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    // Two-stage multiplier standing in for the shared ALU.
    logic signed [31:0] ea, eb;
    logic [31:0] p1 = '0, p2 = '0;
    assign ea = $signed(alu_a);
    assign eb = $signed(alu_b);
    always @(posedge clk) begin
        p1 <= (alu_op_sel == 2'b01) ? ea * eb : 32'h0;
        p2 <= p1;
    end
    assign alu_result = p2;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    // Reference model: plain dot product of sample history and coefficients.
    int mcoef[TAPS];
    int hist[TAPS];
    logic [31:0] exp_q[$];
    time         acc_t_q[$];

    function automatic logic [31:0] model_out();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) begin
            s += longint'(hist[k]) * longint'(mcoef[k]);
        end
`ifdef FIR_SAT_EN
        if (s > longint'(2147483647)) return 32'h7FFF_FFFF;
        if (s < -longint'(2147483647) - 1) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            mcoef[k] = 0;
            hist[k]  = 0;
        end
    endtask

    task automatic wcoef(input int a, input int v);
        int n = 0;
        logic [15:0] v16;
        v16 = 16'(v);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tmo("wcoef_idle");
            return;
        end
        coef_we    = 1'b1;
        coef_addr  = 3'(a);
        coef_wdata = v16;
        mcoef[a]   = int'($signed(v16));
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input bit wr = 1'b0,
                        input int wa = 0, input int wd = 0);
        int n = 0;
        logic [15:0] w16;
        w16 = 16'(wd);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        if (wr) begin
            coef_we    = 1'b1;
            coef_addr  = 3'(wa);
            coef_wdata = w16;
        end
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tmo("send_accept");
            in_valid = 1'b0;
            coef_we  = 1'b0;
            return;
        end
        if (wr) mcoef[wa] = int'($signed(w16));
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'($signed(d));
        exp_q.push_back(model_out());
        @(posedge clk);
        acc_t_q.push_back($time);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) tmo("drain_outputs");
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on each new output.
    bit          seen = 0;
    bit          drop = 0;
    logic [31:0] held = '0;
    int          opc  = 0;
    always @(negedge clk) begin
        if (!rst) begin
            seen = 0;
            drop = 0;
            opc  = 0;
        end else begin
            if (drop) begin
                chk("accept_drop", 32'(out_valid), 32'd0);
                drop = 0;
            end
            if (alu_op_sel == 2'b01) opc++;
            if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        tmo("unexpected_output");
                    end else begin
                        logic [31:0] e;
                        time t;
                        e = exp_q.pop_front();
                        t = acc_t_q.pop_front();
                        chk("out_data", out_data, e);
                        chk("latency", 32'(($time - P/2 - t) / P),
                            32'(TAPS + LAT));
                        chk("issue_count", 32'(opc), 32'(TAPS));
                    end
                    opc  = 0;
                    seen = 1;
                    held = out_data;
                end else begin
                    chk("hold_data", out_data, held);
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                    chk("hold_op", 32'(alu_op_sel), 32'd0);
                end
                if (out_ready) begin
                    seen = 0;
                    drop = 1;
                end
            end
        end
    end

    bit rnd_bp = 0;
    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #(P * 60000);
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int n;
        model_reset();
        #(P * 2 + 2);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;

        for (int k = 0; k < TAPS; k++) wcoef(k, 1);
        send(16'd100);
        for (int i = 0; i < 8; i++) send(16'd0);
        wait_empty();

        for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
        for (int i = 0; i < 9; i++) send(16'd1);
        wait_empty();

        wcoef(0, -2);
        for (int k = 1; k < TAPS; k++) wcoef(k, 0);
        send(16'h8000);
        wcoef(0, -3);
        send(16'd1000);
        wait_empty();

        for (int k = 0; k < TAPS; k++) wcoef(k, -32768);
        for (int i = 0; i < 8; i++) send(16'h8000);
        wait_empty();

        @(posedge clk);
        #1 out_ready = 1'b0;
        send(16'd77);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) tmo("bp_out_valid");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_empty();

        wcoef(0, 7);
        send(16'd10);
        coef_we    = 1'b1;
        coef_addr  = 3'd0;
        coef_wdata = 16'd5;
        repeat (3) @(posedge clk);
        #1 coef_we = 1'b0;
        wait_empty();

        send(16'd55);
        n = 0;
        while (!(busy && alu_op_sel == 2'b00 && !out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) tmo("reach_drain");
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_alu_op", 32'(alu_op_sel), 32'd0);
        exp_q.delete();
        acc_t_q.delete();
        model_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        send(16'd1234);
        wait_empty();

        rnd_bp = 1;
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                wcoef($urandom_range(0, TAPS - 1), $urandom_range(0, 65535));
            end
            if (sel == 1) begin
                send(16'($urandom_range(0, 65535)), 1'b1,
                     $urandom_range(0, TAPS - 1), $urandom_range(0, 65535));
            end else begin
                send(16'($urandom_range(0, 65535)));
            end
        end
        @(posedge clk);
        #2 rnd_bp = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_empty();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
